// File: rtl/cop0_intctl_if.sv
// Bus between the cop0 core and the interrupt controller: external irq lines,
// the shared MTC0/MFC0 register port, and the pending vector fed to Cause.
interface cop0_intctl_if #(
  parameter int NUM_IRQ = 5
);
  logic [NUM_IRQ-1:0] irq_in;
  logic               wr_en;
  logic [4:0]         wr_addr;
  logic [31:0]        wr_data;
  logic [4:0]         rd_addr;
  logic [31:0]        rd_data;
  logic [31:0]        ext_cause_out;
  logic               timer_irq;

  modport master (
    output irq_in, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, ext_cause_out, timer_irq
  );

  modport slave (
    input  irq_in, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, ext_cause_out, timer_irq
  );
endinterface

// File: rtl/cop0_intctl.sv
// cop0 interrupt sources: irq synchroniser, edge latches and Count/Compare timer.
// Define COP0_INTCTL_HALFRATE_EN to make Count advance every other clock.
module cop0_intctl #(
  parameter int         NUM_IRQ     = 5,
  parameter logic [4:0] EDGE_MASK   = 5'b00000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          resetn,
  cop0_intctl_if.slave  bus
);
  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_INTCLR  = 5'd22;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_edge_pend;
  logic [NUM_IRQ-1:0] r_irq_cause;
  logic [31:0]        r_count;
  logic [31:0]        r_compare;
  logic               r_timer_pend;
  logic [31:0]        r_rd_data;

  logic [NUM_IRQ-1:0] w_irq_sync;
  logic [NUM_IRQ-1:0] w_edge_sel;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_pending;
  logic               w_wr_cnt;
  logic               w_wr_cmp;
  logic               w_inc;
  logic               w_first;
  logic               w_match;
  logic [31:0]        w_cause;

  assign w_irq_sync = r_sync[SYNC_STAGES-1];
  assign w_edge_sel = EDGE_MASK[NUM_IRQ-1:0];
  assign w_rise     = w_irq_sync & ~r_prev;
  assign w_clr      = (bus.wr_en && bus.wr_addr == A_INTCLR) ? bus.wr_data[10 +: NUM_IRQ] : '0;
  assign w_wr_cnt   = bus.wr_en && bus.wr_addr == A_COUNT;
  assign w_wr_cmp   = bus.wr_en && bus.wr_addr == A_COMPARE;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.irq_in};
      r_prev <= w_irq_sync;
    end
  end

  // Set beats write-one-to-clear so an edge arriving with the clear is not lost
  always_ff @(posedge clk) begin
    if (!resetn) r_edge_pend <= '0;
    else         r_edge_pend <= ((r_edge_pend & ~w_clr) | w_rise) & w_edge_sel;
  end

  assign w_pending = (w_edge_sel & r_edge_pend) | (~w_edge_sel & w_irq_sync);

  always_ff @(posedge clk) begin
    if (!resetn) r_irq_cause <= '0;
    else         r_irq_cause <= w_pending;
  end

`ifdef COP0_INTCTL_HALFRATE_EN
  logic r_tog;

  always_ff @(posedge clk) begin
    if (!resetn)       r_tog <= 1'b0;
    else if (w_wr_cnt) r_tog <= 1'b0;
    else               r_tog <= ~r_tog;
  end

  // Each Count value lives two clocks; only its first clock may raise the match
  assign w_inc   = r_tog;
  assign w_first = ~r_tog;
`else
  assign w_inc   = 1'b1;
  assign w_first = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!resetn)       r_count <= '0;
    else if (w_wr_cnt) r_count <= bus.wr_data;
    else if (w_inc)    r_count <= r_count + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn)       r_compare <= '0;
    else if (w_wr_cmp) r_compare <= bus.wr_data;
  end

  assign w_match = (r_count == r_compare) && !w_wr_cnt && w_first;

  // Compare write is the only way to acknowledge the timer and wins over a match
  always_ff @(posedge clk) begin
    if (!resetn)       r_timer_pend <= 1'b0;
    else if (w_wr_cmp) r_timer_pend <= 1'b0;
    else if (w_match)  r_timer_pend <= 1'b1;
  end

  always_comb begin
    w_cause                   = '0;
    w_cause[10 +: NUM_IRQ]    = r_irq_cause;
    w_cause[15]               = r_timer_pend;
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_rd_data <= '0;
    else begin
      case (bus.rd_addr)
        A_COUNT:   r_rd_data <= r_count;
        A_COMPARE: r_rd_data <= r_compare;
        A_INTCLR:  r_rd_data <= {16'b0, w_cause[15:8], 8'b0};
        default:   r_rd_data <= '0;
      endcase
    end
  end

  assign bus.ext_cause_out = w_cause;
  assign bus.timer_irq     = r_timer_pend;
  assign bus.rd_data       = r_rd_data;
endmodule

// File: tb/tb_cop0_intctl.sv
// Directed bench for cop0_intctl: register table plus irq/timer corner sequences.
module tb_cop0_intctl;
  localparam int NI = 5;
`ifdef COP0_INTCTL_HALFRATE_EN
  localparam int P = 2;
`else
  localparam int P = 1;
`endif
  localparam int TRISE = 1 + 2 * P;

  logic clk = 1'b0;
  logic resetn;
  int   errors = 0;
  int   checks = 0;

  cop0_intctl_if #(.NUM_IRQ(NI)) bif ();

  cop0_intctl #(.NUM_IRQ(NI), .EDGE_MASK(5'b00001), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .bus(bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic        crd;
    logic [31:0] erd;
    logic        ccause;
  } vec_t;

  vec_t tv[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bif.wr_en = 1'b1; bif.wr_addr = a; bif.wr_data = d;
    step();
    bif.wr_en = 1'b0;
  endtask

  initial begin
    bif.irq_in = 5'h1F; bif.wr_en = 1'b0; bif.wr_addr = '0; bif.wr_data = '0; bif.rd_addr = '0;
    resetn = 1'b0;

    // reset held with all lines asserted
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_cause", bif.ext_cause_out, 32'h0);
      chk("rst_rd", bif.rd_data, 32'h0);
      chk("rst_timer", {31'b0, bif.timer_irq}, 32'h0);
    end
    resetn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k <= 2) chk("rel_lvl_early", {27'b0, bif.ext_cause_out[14:10]}, 32'h0);
      if (k == 3) chk("rel_lvl_rise", {27'b0, bif.ext_cause_out[14:10]}, 32'h1E);
      if (k == 4) chk("rel_edge_rise", {27'b0, bif.ext_cause_out[14:10]}, 32'h1F);
    end
    bif.irq_in = '0;
    wr(5'd22, 32'h7C00);
    for (int k = 0; k < 5; k++) step();
    chk("rel_cleared", {27'b0, bif.ext_cause_out[14:10]}, 32'h0);

    // register table: one row per clock
    tv[0]  = '{1'b1, 5'd9,  32'h100,  5'd9,  1'b0, 32'h0, 1'b0};
    tv[1]  = '{1'b1, 5'd11, 32'h200,  5'd9,  1'b1, 32'h100, 1'b1};
    tv[2]  = '{1'b0, 5'd0,  32'h0,    5'd11, 1'b1, 32'h200, 1'b1};
    tv[3]  = '{1'b1, 5'd11, 32'h300,  5'd11, 1'b1, 32'h200, 1'b1};
    tv[4]  = '{1'b0, 5'd0,  32'h0,    5'd11, 1'b1, 32'h300, 1'b1};
    tv[5]  = '{1'b1, 5'd9,  32'h5000, 5'd9,  1'b1, (P == 2) ? 32'h102 : 32'h104, 1'b1};
    tv[6]  = '{1'b1, 5'd12, 32'hFFFF, 5'd9,  1'b1, 32'h5000, 1'b1};
    tv[7]  = '{1'b0, 5'd0,  32'h0,    5'd12, 1'b1, 32'h0, 1'b1};
    tv[8]  = '{1'b1, 5'd3,  32'hFFFF_FFFF, 5'd9, 1'b1, (P == 2) ? 32'h5001 : 32'h5002, 1'b1};
    tv[9]  = '{1'b1, 5'd22, 32'hFFFF_FFFF, 5'd22, 1'b1, 32'h0, 1'b1};
    tv[10] = '{1'b0, 5'd0,  32'h0,    5'd11, 1'b1, 32'h300, 1'b1};
    for (int i = 0; i < 11; i++) begin
      bif.wr_en = tv[i].we; bif.wr_addr = tv[i].wa; bif.wr_data = tv[i].wd; bif.rd_addr = tv[i].ra;
      step();
      if (tv[i].crd)    chk($sformatf("tbl_rd[%0d]", i), bif.rd_data, tv[i].erd);
      if (tv[i].ccause) chk($sformatf("tbl_cause[%0d]", i), bif.ext_cause_out, 32'h0);
    end
    bif.wr_en = 1'b0; bif.rd_addr = '0;

    // level line 2: 4-cycle pulse
    for (int k = 1; k <= 8; k++) begin
      if (k == 1) bif.irq_in[2] = 1'b1;
      step();
      chk($sformatf("lvl_k%0d", k), {31'b0, bif.ext_cause_out[12]}, {31'b0, (k >= 3 && k <= 6)});
      if (k == 4) bif.irq_in[2] = 1'b0;
    end

    // edge line 0: single-cycle pulse latches
    bif.irq_in[0] = 1'b1;
    step();
    bif.irq_in[0] = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      step();
      if (k == 3 || k == 4 || k == 12)
        chk($sformatf("edge_k%0d", k), {31'b0, bif.ext_cause_out[10]}, {31'b0, k >= 4});
    end
    wr(5'd22, 32'h400);
    step();
    chk("edge_w1c", {31'b0, bif.ext_cause_out[10]}, 32'h0);

    // held high: fresh edge latches, clear sticks while held
    bif.irq_in[0] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("edge_hold_set", {31'b0, bif.ext_cause_out[10]}, 32'h1);
    wr(5'd22, 32'h400);
    step();
    chk("edge_hold_clr", {31'b0, bif.ext_cause_out[10]}, 32'h0);
    for (int k = 0; k < 4; k++) step();
    chk("edge_hold_stay", {31'b0, bif.ext_cause_out[10]}, 32'h0);

    // set and W1C on the same edge: set wins
    bif.irq_in[0] = 1'b0;
    for (int k = 0; k < 4; k++) step();
    bif.irq_in[0] = 1'b1;
    step(); step();
    bif.wr_en = 1'b1; bif.wr_addr = 5'd22; bif.wr_data = 32'h400;
    step();
    bif.wr_en = 1'b0;
    step();
    chk("edge_collide", {31'b0, bif.ext_cause_out[10]}, 32'h1);
    bif.irq_in[0] = 1'b0;
    wr(5'd22, 32'h400);
    for (int k = 0; k < 4; k++) step();

    // timer rise
    wr(5'd11, 32'h20);
    wr(5'd9, 32'h1E);
    for (int k = 1; k <= TRISE; k++) begin
      step();
      if (k >= TRISE - 1) begin
        chk($sformatf("tmr_irq_k%0d", k), {31'b0, bif.timer_irq}, {31'b0, k >= TRISE});
        chk($sformatf("tmr_cause_k%0d", k), bif.ext_cause_out, (k >= TRISE) ? 32'h8000 : 32'h0);
      end
    end
    step();
    chk("tmr_hold", {31'b0, bif.timer_irq}, 32'h1);
    wr(5'd11, 32'h100);
    chk("tmr_ack", bif.ext_cause_out, 32'h0);

    // compare write on the match edge: clear wins
    wr(5'd11, 32'h50);
    wr(5'd9, 32'h4E);
    for (int k = 1; k < TRISE; k++) step();
    wr(5'd11, 32'h50);
    chk("tmr_collide", {31'b0, bif.timer_irq}, 32'h0);
    for (int k = 0; k < 3; k++) step();
    chk("tmr_collide_stay", {31'b0, bif.timer_irq}, 32'h0);

    // count written during its matching cycle: no set
    wr(5'd11, 32'h40);
    wr(5'd9, 32'h40);
    wr(5'd9, 32'h80);
    chk("tmr_cntwr", {31'b0, bif.timer_irq}, 32'h0);
    step();
    chk("tmr_cntwr2", {31'b0, bif.timer_irq}, 32'h0);

    // wrap and readback
    wr(5'd11, 32'h1);
    bif.rd_addr = 5'd9;
    wr(5'd9, 32'hFFFF_FFFE);
    for (int k = 1; k <= 1 + 3 * P; k++) begin
      step();
      if (k == 1 + P)     chk("wrap_rd0", bif.rd_data, 32'hFFFF_FFFF);
      if (k == 1 + 2 * P) chk("wrap_rd1", bif.rd_data, 32'h0);
      if (k == 3 * P)     chk("wrap_tmr_pre", {31'b0, bif.timer_irq}, 32'h0);
      if (k == 1 + 3 * P) begin
        chk("wrap_rd2", bif.rd_data, 32'h1);
        chk("wrap_tmr", {31'b0, bif.timer_irq}, 32'h1);
      end
    end
    bif.rd_addr = 5'd22;
    step();
    chk("rd_intclr", bif.rd_data, 32'h8000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
